prio_enc_rr: RTL and testbench
==============================

Name: prio_enc_rr

Overview:
- Parametrised N-to-log2(N) priority encoder with one registered output stage and valid/ready handshakes on both sides.
- Two modes, selected per request:
  - fixed priority, where the highest set index wins;
  - round-robin, where the search starts just below the last grant and wraps.
- Used wherever the design arbitrates among request lines and needs a registered index that downstream logic can back-pressure.

Parameters:
- WIDTH, 8: number of request lines. Must be ≥ 2 and a power of 2.
- IDX_W, $clog2(WIDTH): width of the index output. Derived from WIDTH; never overridden.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream presents in_req and mode.
- in_ready  out  1  block can accept this cycle.
- in_req  in  WIDTH  request vector; bit i set means line i is requesting.
- mode  in  1  0 = fixed priority (MSB first), 1 = round-robin; sampled with in_req.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- out_idx  out  IDX_W  encoded winning index.
- out_none  out  1  accepted in_req was all-zero.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - out_valid = 0, out_idx = 0, out_none = 0, internal pointer ptr = 0.
  - Reset takes priority over any simultaneous accept or consume; an in-flight result is discarded.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput: one accept per cycle while out_ready = 1.
- Accept happens when in_valid && in_ready.
  - On the next edge: out_valid = 1, and out_idx/out_none are loaded.
  - Latency is exactly 1 cycle from accept to out_valid.
- Consume happens when out_valid && out_ready. If there is no simultaneous accept, out_valid = 0 on the next edge.
- Simultaneous consume and accept: out_valid stays 1 and the new result replaces the old one.
- While out_valid && !out_ready:
  - out_idx and out_none are held stable;
  - in_req, mode and in_valid are ignored.
- Fixed mode (mode = 0):
  - out_idx = highest i with in_req[i] = 1.
  - ptr is not updated.
- Round-robin mode (mode = 1):
  - Search order is ptr-1, ptr-2, …, 0, WIDTH-1, …, ptr, with modulo-WIDTH wrap.
  - The first set bit wins.
  - On an accept with a non-zero request, ptr <= winning index.
  - With ptr = 0 the order is WIDTH-1 down to 0, identical to fixed mode.
- All-zero in_req (either mode):
  - out_none = 1, out_idx = 0;
  - ptr unchanged.
- Single set bit: that index wins in both modes regardless of ptr.
- Mode switch:
  - takes effect on the accept at which the new mode is sampled;
  - ptr is preserved across switches and never cleared except by reset.
- out_idx and out_none are driven only from registers; there is no combinational path from in_req to the outputs.

Decomposition:
- Shared package contents:
  - PRIO_MODE_FIXED = 1'b0, PRIO_MODE_RR = 1'b1;
  - a function computing IDX_W from WIDTH.
- Sub-module prio_scan (parameter WIDTH):
  - combinational; inputs req[WIDTH] and start[IDX_W];
  - outputs idx and found;
  - scans descending from start with wrap.
- The top block feeds start = WIDTH-1 in fixed mode and start = ptr-1 (mod WIDTH) in round-robin mode.
- The top block holds the handshake, the result register and ptr.

Test Plan:
- Fixed select (WIDTH = 8, mode = 0, out_ready = 1): after reset, accept in_req = 8'b0010_1100 → next cycle out_valid = 1, out_idx = 5, out_none = 0.
- Zero request: accept in_req = 8'h00 → out_none = 1, out_idx = 0; a following round-robin accept of 8'hFF still yields 7 (ptr was not moved).
- Round-robin sweep (mode = 1, in_req = 8'hFF, 9 consecutive accepts, out_ready = 1) → out_idx sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, with one result per cycle.
- Round-robin wrap (ptr = 5 after a grant of 5): in_req = 8'b1010_0001 → out_idx = 0; the same request again → out_idx = 7.
- Back-pressure: with out_valid = 1, hold out_ready = 0 for 3 cycles while changing in_req → in_ready = 0 and outputs stable throughout. Raising out_ready with in_valid = 1 consumes and accepts in the same cycle, and the new result appears on the next edge.
- Reset mid-operation: rst_n = 0 for one edge while out_valid = 1 and ptr = 3 → out_valid = 0 and out_idx = 0; a following round-robin accept of 8'hFF → out_idx = 7.

Source files
------------

// File: rtl/prio_enc_rr_pkg.sv
// Shared definitions for the round-robin / fixed-priority encoder.
package prio_enc_rr_pkg;

    localparam logic PRIO_MODE_FIXED = 1'b0;
    localparam logic PRIO_MODE_RR    = 1'b1;

    // Index width for a given number of request lines (at least one bit).
    function automatic int idx_width(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/prio_enc_rr_scan.sv
// Combinational descending scan of a request vector starting at start_i,
// wrapping from 0 back to WIDTH-1; the first set bit found wins.
module prio_scan
    import prio_enc_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] pos_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Walk start, start-1, ... with natural power-of-two wrap; keep the first hit.
    always_comb begin
        idx_s   = {IDX_W{1'b0}};
        found_s = 1'b0;
        pos_s   = {IDX_W{1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            pos_s = start_i - k[IDX_W-1:0];
            if (!found_s && req_i[pos_s]) begin
                found_s = 1'b1;
                idx_s   = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idx_o   = idx_s;
    assign found_o = found_s;

endmodule

// File: rtl/prio_enc_rr.sv
// Priority encoder with fixed or round-robin selection, one registered
// result stage and valid/ready handshakes on both sides.
module prio_enc_rr
    import prio_enc_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none
);

    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_none_q, out_none_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             accept_s;
    logic [IDX_W-1:0] start_s;
    logic [IDX_W-1:0] scan_idx_s;
    logic             scan_found_s;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Round-robin resumes just below the last grant; ptr = 0 wraps to the MSB.
    always_comb begin
        if (mode == PRIO_MODE_RR) begin
            start_s = ptr_q - {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            start_s = {IDX_W{1'b1}};
        end
    end

    prio_scan #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_scan (
        .req_i   (in_req),
        .start_i (start_s),
        .idx_o   (scan_idx_s),
        .found_o (scan_found_s)
    );

    // Next-state for the result register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_none_d  = out_none_q;
        ptr_d       = ptr_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_none_d  = !scan_found_s;
            out_idx_d   = scan_found_s ? scan_idx_s : {IDX_W{1'b0}};
            if ((mode == PRIO_MODE_RR) && scan_found_s) begin
                ptr_d = scan_idx_s;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= {IDX_W{1'b0}};
            out_none_q  <= 1'b0;
            ptr_q       <= {IDX_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_none_q  <= out_none_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_none  = out_none_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed-vector bench for prio_enc_rr (WIDTH = 8) with hand-computed results.
module tb_prio_enc_rr;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_req;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_none;

    int checks   = 0;
    int failures = 0;

    prio_enc_rr #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic m);
        in_valid = v;
        in_req   = r;
        mode     = m;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] i, input logic n);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_idx"},   32'(out_idx),   32'(i));
        check({tag, "_none"},  32'(out_none),  32'(n));
    endtask

    logic [2:0] sweep_exp [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        expect_out("reset", 1'b0, 3'd0, 1'b0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Fixed priority select
        rst_n = 1'b1;
        drive(1'b1, 8'b0010_1100, 1'b0);
        step();
        expect_out("fixed_2c", 1'b1, 3'd5, 1'b0);

        // Zero request, then RR with untouched pointer
        drive(1'b1, 8'h00, 1'b0);
        step();
        expect_out("zero", 1'b1, 3'd0, 1'b1);
        drive(1'b1, 8'hFF, 1'b1);
        step();
        expect_out("rr_after_zero", 1'b1, 3'd7, 1'b0);

        // Fresh reset then RR sweep, one result per cycle
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 8'hFF, 1'b1);
            step();
            check($sformatf("sweep%0d_idx", k), 32'(out_idx), 32'(sweep_exp[k]));
            check($sformatf("sweep%0d_valid", k), 32'(out_valid), 32'd1);
        end

        // Pointer to 5 via single bit, then wrap behaviour
        drive(1'b1, 8'h20, 1'b1);
        step();
        expect_out("single5", 1'b1, 3'd5, 1'b0);
        drive(1'b1, 8'b1010_0001, 1'b1);
        step();
        expect_out("wrap0", 1'b1, 3'd0, 1'b0);
        drive(1'b1, 8'b1010_0001, 1'b1);
        step();
        expect_out("wrap7", 1'b1, 3'd7, 1'b0);

        // Back-pressure: outputs held, inputs ignored
        out_ready = 1'b0;
        drive(1'b1, 8'h08, 1'b0);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'(8'h01 << k), k[0]);
            step();
            expect_out($sformatf("bp%0d", k), 1'b1, 3'd7, 1'b0);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        drive(1'b1, 8'h08, 1'b0);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        expect_out("bp_release", 1'b1, 3'd3, 1'b0);

        // Consume without accept drops out_valid
        drive(1'b0, 8'hFF, 1'b1);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Fixed mode ignores a non-zero pointer (ptr is 7 here)
        drive(1'b1, 8'h09, 1'b1);
        step();
        expect_out("rr_ptr3", 1'b1, 3'd3, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        step();
        expect_out("fixed_ptr3", 1'b1, 3'd7, 1'b0);

        // Reset mid-operation with ptr = 3 and a pending result
        rst_n = 1'b0;
        drive(1'b1, 8'hFF, 1'b1);
        step();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_idx", 32'(out_idx), 32'd0);
        rst_n = 1'b1;
        step();
        expect_out("post_rst_rr", 1'b1, 3'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
